mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous main memory (12-bit words, 1-cycle read latency) between two requesters.
- Port 0 is the CPU core fetch/load/store path. Port 1 is the UART program loader / debug DMA.
- Round-robin arbitration, with an optional bounded burst lock so a requester can finish multi-word transfers.
- Sits between the core and the memory instance and drives all memory control inputs.

Parameters:
- ADDR_WIDTH, 12, memory address width.
- DATA_WIDTH, 12, memory word width.
- MAX_HOLD, 4, maximum consecutive grants a locking requester keeps while the other port is requesting (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_0, req_1  in  1  access request; held until the matching gnt is seen
- we_0, we_1  in  1  1 = write, 0 = read; qualified by req
- lock_0, lock_1  in  1  burst lock; ask to keep the grant next cycle
- addr_0, addr_1  in  ADDR_WIDTH  word address
- wdata_0, wdata_1  in  DATA_WIDTH  write data
- gnt_0, gnt_1  out  1  combinational; access performed at this clock edge
- rvalid_0, rvalid_1  out  1  registered; read data valid this cycle
- rdata  out  DATA_WIDTH  equals mem_data_out; shared by both ports, qualified by rvalid_x
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_write_enable  out  1  to memory write_enable
- mem_data_in  out  DATA_WIDTH  to memory data_in
- mem_data_out  in  DATA_WIDTH  from memory data_out
- busy  out  1  gnt_0 | gnt_1

Behaviour:
- At most one grant per cycle; gnt_0 & gnt_1 is never 1.
- Grant decision is combinational from req_x and the registered state (last_winner, hold_cnt, owner_locked).
- Memory inputs are a combinational mux of the winner's addr/wdata. mem_write_enable = gnt_x & we_x.
- When no port is granted: mem_addr = 0, mem_write_enable = 0, mem_data_in = 0.
- Only one port requesting: that port wins every cycle, no bubbles.
- Both requesting, no active lock: the port not in last_winner wins.
- Both requesting, locked owner: the previous winner w wins again if lock_w was 1 on its last grant and hold_cnt < MAX_HOLD. Otherwise the other port wins.
- State update each edge with a grant:
  - last_winner <= winner.
  - owner_locked <= lock_winner.
  - hold_cnt <= (winner == last_winner) ? saturating hold_cnt+1 : 1.
- State update each edge without a grant: owner_locked <= 0, hold_cnt <= 0, last_winner unchanged.
- hold_cnt is 4 bits and saturates at 15; it never wraps.
- Lock while the other port is idle does not count against fairness in practice: it only matters once both request.
- Read latency: read granted at edge N gives rvalid_x = 1 during cycle N+1, with rdata = memory word. rvalid is a single-cycle pulse per read grant.
- Write grants never produce rvalid.
- Back-to-back reads alternating ports give alternating rvalid pulses, one cycle after each grant.
- A write then a read to the same address on consecutive cycles returns the new data. Memory is write-then-read across edges; no bypass is needed.
- Requester dropping req without a grant is legal; no state change.
- Reset (sampled at edge), all registered outputs and state:
  - rvalid_0/1 = 0, last_winner = 1 (so port 0 wins the first contention), hold_cnt = 0, owner_locked = 0.
  - While reset = 1: gnt_0/1 forced 0 and mem_write_enable forced 0.
- Reset mid-read: the rvalid pending for that read is dropped. The requester must reissue the read.

Test Plan:
- After reset, req_0 = req_1 = 1 reads, addr_0 = 5, addr_1 = 9, mem[5] = 0x0AA, mem[9] = 0x155 -> gnt_0 cycle 1, gnt_1 cycle 2; rvalid_0 with rdata = 0x0AA cycle 2; rvalid_1 with rdata = 0x155 cycle 3.
- req_1 only, write addr 3 data 0xFFF, then req_0 read addr 3 next cycle -> gnt_1, mem_write_enable = 1 for one cycle; gnt_0 next cycle; rvalid_0 with rdata = 0xFFF.
- Port 1 lock = 1, req held for 8 cycles, port 0 requesting throughout, MAX_HOLD = 4 -> grant sequence 1,1,1,1,0,1,1,1 (after handover, port 1 regains and is capped again).
- Both requesting continuously, lock = 0 -> strict alternation 0,1,0,1…; never both granted; mem_write_enable only with a write grant.
- Read granted at edge N, reset asserted at edge N+1 -> rvalid_0 = 0 in cycle N+1 and onward; next contention after reset grants port 0 first.
- No requests for 3 cycles -> busy = 0, mem_write_enable = 0, hold_cnt = 0; next single req_1 is granted the same cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus between the two memory requesters, the arbiter and the single-port main memory.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  req_0, req_1;
    logic                  we_0, we_1;
    logic                  lock_0, lock_1;
    logic [ADDR_WIDTH-1:0] addr_0, addr_1;
    logic [DATA_WIDTH-1:0] wdata_0, wdata_1;
    logic                  gnt_0, gnt_1;
    logic                  rvalid_0, rvalid_1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  busy;

    modport slave (
        input  req_0, req_1, we_0, we_1, lock_0, lock_1,
        input  addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata,
        output mem_addr, mem_write_enable, mem_data_in, busy
    );

    modport master (
        output req_0, req_1, we_0, we_1, lock_0, lock_1,
        output addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata,
        input  mem_addr, mem_write_enable, mem_data_in, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port main memory, with a bounded
// burst lock so the current owner can finish a multi-word transfer.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int MAX_HOLD   = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic       last_winner_q, last_winner_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       owner_locked_q, owner_locked_d;
    logic [1:0] rvalid_q, rvalid_d;

    logic gnt0, gnt1, lock_active;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_data_in_c;
    logic                  mem_we_c;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q  <= 1'b1;
            hold_cnt_q     <= 4'd0;
            owner_locked_q <= 1'b0;
            rvalid_q       <= 2'b00;
        end else begin
            last_winner_q  <= last_winner_d;
            hold_cnt_q     <= hold_cnt_d;
            owner_locked_q <= owner_locked_d;
            rvalid_q       <= rvalid_d;
        end
    end

    // Grant decision: a sole requester always wins; under contention the lock keeps the
    // previous winner only while its hold count is below the limit.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        lock_active = owner_locked_q && (hold_cnt_q < HOLD_LIMIT);
        if (!reset) begin
            if (bus.req_0 && bus.req_1) begin
                gnt1 = lock_active ? last_winner_q : ~last_winner_q;
                gnt0 = ~gnt1;
            end else begin
                gnt0 = bus.req_0;
                gnt1 = bus.req_1;
            end
        end
    end

    always_comb begin
        last_winner_d  = last_winner_q;
        hold_cnt_d     = 4'd0;
        owner_locked_d = 1'b0;
        rvalid_d       = {gnt1 & ~bus.we_1, gnt0 & ~bus.we_0};
        if (gnt0 || gnt1) begin
            last_winner_d  = gnt1;
            owner_locked_d = gnt1 ? bus.lock_1 : bus.lock_0;
            hold_cnt_d     = (gnt1 == last_winner_q) ? sat_inc(hold_cnt_q) : 4'd1;
        end
    end

    always_comb begin
        mem_addr_c    = '0;
        mem_data_in_c = '0;
        mem_we_c      = 1'b0;
        if (gnt0) begin
            mem_addr_c    = bus.addr_0;
            mem_data_in_c = bus.wdata_0;
            mem_we_c      = bus.we_0;
        end else if (gnt1) begin
            mem_addr_c    = bus.addr_1;
            mem_data_in_c = bus.wdata_1;
            mem_we_c      = bus.we_1;
        end
    end

    assign bus.gnt_0            = gnt0;
    assign bus.gnt_1            = gnt1;
    assign bus.busy             = gnt0 | gnt1;
    assign bus.mem_addr         = mem_addr_c;
    assign bus.mem_data_in      = mem_data_in_c;
    assign bus.mem_write_enable = mem_we_c;
    assign bus.rdata            = bus.mem_data_out;
    // A read in flight when reset rises is dropped, so its pulse is masked as well.
    assign bus.rvalid_0         = rvalid_q[0] & ~reset;
    assign bus.rvalid_1         = rvalid_q[1] & ~reset;
endmodule
